// File: rtl/ram_port_arbiter_if.sv
// Bus bundle for ram_port_arbiter: fetch port, load/store port and the RAMHelper port.
// The arbiter takes the slave view; the core/RAM side (or a testbench) takes the master view.
interface ram_port_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        if_resp_ready;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        mem_resp_ready;

  logic        ram_ren;
  logic [63:0] ram_ridx;
  logic [63:0] ram_rdata;
  logic        ram_wen;
  logic [63:0] ram_widx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;

  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_resp_ready,
    input  ram_rdata,
    output if_req_ready, if_resp_valid, if_resp_inst,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output ram_ren, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
  );

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_resp_ready,
    output ram_rdata,
    input  if_req_ready, if_resp_valid, if_resp_inst,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  ram_ren, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAMHelper port between instruction fetch and load/store, one request in flight.
// Data side has priority; fetch is forced through after STARVE_LIMIT consecutive denials.
module ram_port_arbiter #(
  parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_8000_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  ram_port_arbiter_if.slave   io_bus
);
  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  logic [3:0]  r_starve_cnt;
  logic        r_owner_mem;
  logic        r_is_write;
  logic        r_half;
  logic        r_first;
  logic [63:0] r_hold;
  logic        r_if_resp_valid;
  logic        r_mem_resp_valid;

  logic        w_idle;
  logic        w_grant_if;
  logic        w_grant_mem;
  logic        w_accept_if;
  logic        w_accept_mem;
  logic        w_read;
  logic        w_write;
  logic [63:0] w_addr;
  logic [63:0] w_idx;
  logic [63:0] w_wmask;
  logic [63:0] w_data;
  logic        w_handshake;

  // rst is folded in so a reset during an accept cycle kills the RAM command at once
  assign w_idle       = rst & (r_state == IDLE);
  assign w_grant_if   = io_bus.if_req_valid & (~io_bus.mem_req_valid | (r_starve_cnt == LIMIT));
  assign w_grant_mem  = io_bus.mem_req_valid & ~w_grant_if;
  assign w_accept_if  = w_idle & w_grant_if;
  assign w_accept_mem = w_idle & w_grant_mem;
  assign w_write      = w_accept_mem & io_bus.mem_req_we;
  assign w_read       = w_accept_if | (w_accept_mem & ~io_bus.mem_req_we);

  assign w_addr = w_grant_if ? io_bus.if_req_addr : io_bus.mem_req_addr;
  assign w_idx  = (w_addr - BASE_ADDR) >> 3;

  always_comb begin
    w_wmask = '0;
    for (int k = 0; k < 8; k++) begin
      w_wmask[8*k +: 8] = {8{io_bus.mem_req_wstrb[k]}};
    end
  end

  assign io_bus.if_req_ready  = w_accept_if;
  assign io_bus.mem_req_ready = w_accept_mem;
  assign io_bus.ram_ren       = w_read;
  assign io_bus.ram_ridx      = w_read  ? w_idx : '0;
  assign io_bus.ram_wen       = w_write;
  assign io_bus.ram_widx      = w_write ? w_idx : '0;
  assign io_bus.ram_wdata     = w_write ? io_bus.mem_req_wdata : '0;
  assign io_bus.ram_wmask     = w_write ? w_wmask : '0;

  // RAM data is only valid in the first response cycle; after that the captured copy is used
  assign w_data = r_first ? io_bus.ram_rdata : r_hold;

  assign io_bus.if_resp_valid  = r_if_resp_valid;
  assign io_bus.mem_resp_valid = r_mem_resp_valid;
  assign io_bus.if_resp_inst   = r_if_resp_valid ? (r_half ? w_data[63:32] : w_data[31:0]) : '0;
  assign io_bus.mem_resp_rdata = (r_mem_resp_valid & ~r_is_write) ? w_data : '0;

  assign w_handshake = r_owner_mem ? (r_mem_resp_valid & io_bus.mem_resp_ready)
                                   : (r_if_resp_valid & io_bus.if_resp_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= IDLE;
      r_starve_cnt     <= '0;
      r_owner_mem      <= 1'b0;
      r_is_write       <= 1'b0;
      r_half           <= 1'b0;
      r_first          <= 1'b0;
      r_hold           <= '0;
      r_if_resp_valid  <= 1'b0;
      r_mem_resp_valid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (!io_bus.if_req_valid || w_grant_if) begin
        r_starve_cnt <= '0;
      end else if (w_grant_mem && r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
      if (w_grant_if || w_grant_mem) begin
        r_state          <= RESP;
        r_owner_mem      <= w_grant_mem;
        r_is_write       <= w_grant_mem & io_bus.mem_req_we;
        r_half           <= io_bus.if_req_addr[2];
        r_first          <= 1'b1;
        r_if_resp_valid  <= w_grant_if;
        r_mem_resp_valid <= w_grant_mem;
      end
    end else begin
      if (r_first) begin
        r_hold  <= io_bus.ram_rdata;
        r_first <= 1'b0;
      end
      if (w_handshake) begin
        r_state          <= IDLE;
        r_if_resp_valid  <= 1'b0;
        r_mem_resp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: combinational command vectors from a table,
// then hand-written sequences for responses, arbitration, stalls, reset and starvation.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  ram_port_arbiter_if bus();

  ram_port_arbiter #(
    .BASE_ADDR   (64'h0000_0000_8000_0000),
    .STARVE_LIMIT(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifValid;
    logic [63:0] ifAddr;
    logic        memValid;
    logic        memWe;
    logic [63:0] memAddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        expIfReady;
    logic        expMemReady;
    logic        expRen;
    logic [63:0] expRidx;
    logic        expWen;
    logic [63:0] expWidx;
    logic [63:0] expWdata;
    logic [63:0] expWmask;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.if_req_valid  = v.ifValid;
    bus.if_req_addr   = v.ifAddr;
    bus.mem_req_valid = v.memValid;
    bus.mem_req_we    = v.memWe;
    bus.mem_req_addr  = v.memAddr;
    bus.mem_req_wdata = v.wdata;
    bus.mem_req_wstrb = v.wstrb;
  endtask

  // Keeps both requesters valid with responses always accepted, recording who is granted
  task automatic runGrants(input string expSeq);
    logic seenIf[0:15];
    int   got = 0;
    int   cyc = 0;
    bus.if_req_valid   = 1'b1;
    bus.mem_req_valid  = 1'b1;
    bus.mem_req_we     = 1'b0;
    bus.if_resp_ready  = 1'b1;
    bus.mem_resp_ready = 1'b1;
    while (got < expSeq.len() && cyc < 100) begin
      #1;
      cyc++;
      if (bus.if_req_ready || bus.mem_req_ready) begin
        seenIf[got] = bus.if_req_ready;
        got++;
      end
      if (got < expSeq.len()) @(negedge clk);
    end
    checkOutput("grantCount", 64'(got), 64'(expSeq.len()));
    for (int i = 0; i < got; i++) begin
      checkBit($sformatf("grant%0d_isFetch", i), seenIf[i], expSeq[i] == 8'h49);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 64'h8000_0004, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00,
                1'b1, 1'b0, 1'b1, 64'h0, 1'b0, 64'h0, 64'h0, 64'h0};
    vecs[1] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F,
                1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h2, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_FFFF_FFFF};
    vecs[2] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0027, 64'h1234, 8'hFF,
                1'b0, 1'b1, 1'b1, 64'h4, 1'b0, 64'h0, 64'h0, 64'h0};
    vecs[3] = '{1'b1, 64'h8000_0008, 1'b1, 1'b0, 64'h8000_0100, 64'h0, 8'h00,
                1'b0, 1'b1, 1'b1, 64'h20, 1'b0, 64'h0, 64'h0, 64'h0};
    vecs[4] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h8000_1000, 64'h0102_0304_0506_0708, 8'hA5,
                1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h200, 64'h0102_0304_0506_0708, 64'hFF00_FF00_00FF_00FF};
    vecs[5] = '{1'b1, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00,
                1'b1, 1'b0, 1'b1, 64'h1FFF_FFFF_F000_0000, 1'b0, 64'h0, 64'h0, 64'h0};
    vecs[6] = '{1'b0, 64'h8000_0004, 1'b0, 1'b1, 64'h8000_0010, 64'hFFFF, 8'hFF,
                1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 64'h0};

    bus.if_req_valid   = 1'b1;
    bus.if_req_addr    = 64'h8000_0000;
    bus.if_resp_ready  = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_we     = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_wdata  = '0;
    bus.mem_req_wstrb  = '0;
    bus.mem_resp_ready = 1'b0;
    bus.ram_rdata      = '0;

    #3;
    checkBit("reset_ifReady", bus.if_req_ready, 1'b0);
    checkBit("reset_ren", bus.ram_ren, 1'b0);
    checkBit("reset_ifRespValid", bus.if_resp_valid, 1'b0);
    checkBit("reset_memRespValid", bus.mem_resp_valid, 1'b0);
    checkOutput("reset_memRdata", bus.mem_resp_rdata, 64'h0);
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Command decode per vector; valids drop before the clock edge so nothing is accepted
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkBit($sformatf("vec%0d_ifReady", i), bus.if_req_ready, vecs[i].expIfReady);
      checkBit($sformatf("vec%0d_memReady", i), bus.mem_req_ready, vecs[i].expMemReady);
      checkBit($sformatf("vec%0d_ren", i), bus.ram_ren, vecs[i].expRen);
      checkOutput($sformatf("vec%0d_ridx", i), bus.ram_ridx, vecs[i].expRidx);
      checkBit($sformatf("vec%0d_wen", i), bus.ram_wen, vecs[i].expWen);
      checkOutput($sformatf("vec%0d_widx", i), bus.ram_widx, vecs[i].expWidx);
      checkOutput($sformatf("vec%0d_wdata", i), bus.ram_wdata, vecs[i].expWdata);
      checkOutput($sformatf("vec%0d_wmask", i), bus.ram_wmask, vecs[i].expWmask);
      #1;
      bus.if_req_valid  = 1'b0;
      bus.mem_req_valid = 1'b0;
    end

    // Fetch read, upper instruction lane
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h8000_0004;
    bus.ram_rdata    = 64'h1122_3344_5566_7788;
    #1;
    checkBit("fetch_ren", bus.ram_ren, 1'b1);
    checkOutput("fetch_ridx", bus.ram_ridx, 64'h0);
    checkBit("fetch_ready", bus.if_req_ready, 1'b1);
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    #1;
    checkBit("fetch_respValid", bus.if_resp_valid, 1'b1);
    checkOutput("fetch_inst", {32'h0, bus.if_resp_inst}, 64'h1122_3344);
    checkBit("fetch_memRespValid", bus.mem_resp_valid, 1'b0);
    checkBit("fetch_renAfter", bus.ram_ren, 1'b0);
    bus.if_resp_ready = 1'b1;
    @(negedge clk);
    #1;
    checkBit("fetch_respDone", bus.if_resp_valid, 1'b0);
    bus.if_resp_ready = 1'b0;

    // Data write with partial strobes
    @(negedge clk);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_we    = 1'b1;
    bus.mem_req_addr  = 64'h8000_0010;
    bus.mem_req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    bus.mem_req_wstrb = 8'h0F;
    #1;
    checkBit("write_wen", bus.ram_wen, 1'b1);
    checkOutput("write_widx", bus.ram_widx, 64'h2);
    checkOutput("write_wmask", bus.ram_wmask, 64'h0000_0000_FFFF_FFFF);
    checkBit("write_ren", bus.ram_ren, 1'b0);
    @(negedge clk);
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_we     = 1'b0;
    bus.mem_resp_ready = 1'b1;
    #1;
    checkBit("write_respValid", bus.mem_resp_valid, 1'b1);
    checkOutput("write_rdata", bus.mem_resp_rdata, 64'h0);
    checkBit("write_wenAfter", bus.ram_wen, 1'b0);
    @(negedge clk);
    #1;
    checkBit("write_respDone", bus.mem_resp_valid, 1'b0);
    bus.mem_resp_ready = 1'b0;

    // Arbitration with both requesters always valid
    runGrants("MMMMIMMMMI");
    @(negedge clk);
    bus.if_req_valid  = 1'b0;
    bus.mem_req_valid = 1'b0;
    @(negedge clk);
    bus.if_resp_ready  = 1'b0;
    bus.mem_resp_ready = 1'b0;

    // Stalled data read: response must ignore later ram_rdata changes
    @(negedge clk);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = 64'h8000_0008;
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 64'h8000_0000;
    #1;
    checkBit("stall_memReady", bus.mem_req_ready, 1'b1);
    checkOutput("stall_ridx", bus.ram_ridx, 64'h1);
    @(negedge clk);
    bus.ram_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    checkBit("stall_respValid0", bus.mem_resp_valid, 1'b1);
    checkOutput("stall_rdata0", bus.mem_resp_rdata, 64'h0123_4567_89AB_CDEF);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.ram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      checkBit($sformatf("stall_respValid%0d", i), bus.mem_resp_valid, 1'b1);
      checkOutput($sformatf("stall_rdata%0d", i), bus.mem_resp_rdata, 64'h0123_4567_89AB_CDEF);
      checkBit($sformatf("stall_ifReady%0d", i), bus.if_req_ready, 1'b0);
      checkBit($sformatf("stall_memReady%0d", i), bus.mem_req_ready, 1'b0);
    end
    bus.if_req_valid   = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_resp_ready = 1'b1;
    @(negedge clk);
    #1;
    checkBit("stall_respDone", bus.mem_resp_valid, 1'b0);
    bus.mem_resp_ready = 1'b0;

    // Reset asserted while a fetch response is pending
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 64'h8000_0004;
    @(negedge clk);
    #1;
    checkBit("rstmid_respBefore", bus.if_resp_valid, 1'b1);
    rst = 1'b0;
    #1;
    checkBit("rstmid_respValid", bus.if_resp_valid, 1'b0);
    checkOutput("rstmid_inst", {32'h0, bus.if_resp_inst}, 64'h0);
    checkBit("rstmid_ren", bus.ram_ren, 1'b0);
    checkBit("rstmid_ifReady", bus.if_req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.if_req_addr   = 64'h8000_0000;
    bus.ram_rdata     = 64'hAAAA_BBBB_CCCC_DDDD;
    bus.if_resp_ready = 1'b1;
    #1;
    checkBit("rstrel_noResp", bus.if_resp_valid, 1'b0);
    checkBit("rstrel_ifReady", bus.if_req_ready, 1'b1);
    checkBit("rstrel_ren", bus.ram_ren, 1'b1);
    checkOutput("rstrel_ridx", bus.ram_ridx, 64'h0);
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    #1;
    checkBit("rstrel_respValid", bus.if_resp_valid, 1'b1);
    checkOutput("rstrel_inst", {32'h0, bus.if_resp_inst}, 64'hCCCC_DDDD);
    @(negedge clk);
    bus.if_resp_ready = 1'b0;

    // Build starvation count of 3, then a lone fetch must win and clear it
    runGrants("MMM");
    @(negedge clk);
    bus.mem_req_valid = 1'b0;
    @(negedge clk);
    #1;
    checkBit("lone_ifReady", bus.if_req_ready, 1'b1);
    checkBit("lone_memReady", bus.mem_req_ready, 1'b0);
    @(negedge clk);
    runGrants("MMMMI");
    @(negedge clk);
    bus.if_req_valid  = 1'b0;
    bus.mem_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
